filter_coef_loader: RTL and testbench
=====================================

# filter_coef_loader

Writer-side companion to the biquad filter stage. It accepts coefficient writes from the synth control path over a valid/ready stream and stages them in a shadow bank. On an explicit commit it transfers the whole set to the filter's active coefficient inputs, aligned to the audio sample strobe, so the filter never runs a sample with a mixed old/new coefficient set.

## Interface
Parameters:
- `B0_RST`, default 16'sh7FFF: reset value of b0 (Q1.15).
- `B1_RST`, default 16'sh0000: reset value of b1.
- `B2_RST`, default 16'sh0000: reset value of b2.
- `A0_RST`, default 16'sh7FFF: reset value of a0.
- `A1_RST`, default 16'sh0000: reset value of a1.
- `A2_RST`, default 16'sh0000: reset value of a2.

Ports:
- `Clk`  in  1  system clock; the only clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `sample_tick`  in  1  one-cycle strobe; the filter's sample registers advance on this cycle.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  loader can accept a write.
- `wr_addr`  in  3  coefficient index: 0=b0, 1=b1, 2=b2, 3=a0, 4=a1, 5=a2; 6 and 7 are invalid.
- `wr_data`  in  16 signed  coefficient value, Q1.15.
- `wr_last`  in  1  this write ends the set and requests a commit.
- `b0, b1, b2, a0, a1, a2`  out  16 signed each  active coefficients, driven to the filter.
- `written_mask`  out  6  shadow entries written since the last commit; bit i corresponds to index i.
- `update_pending`  out  1  high while a commit is armed.
- `update_done`  out  1  one-cycle pulse on the cycle the active set changes.
- `addr_err`  out  1  one-cycle pulse when a write to an invalid address is accepted.

## Operation
- The state machine has three states:
  - IDLE: `wr_ready`=1. An accepted write moves to COLLECT, or to ARMED if `wr_last`=1.
  - COLLECT: `wr_ready`=1. An accepted write with `wr_last`=1 moves to ARMED.
  - ARMED: `wr_ready`=0 and `update_pending`=1. On `sample_tick`: copy shadow to active, pulse `update_done`, clear `written_mask`, go to IDLE.
- A write is accepted when `wr_valid` and `wr_ready` are both high. An accepted write to a valid address stores `wr_data` in `shadow[wr_addr]` and sets the matching `written_mask` bit.
- A write to address 6 or 7 is still accepted, but the data is dropped and `addr_err` pulses. Its `wr_last` still arms the commit.
- Partial sets are legal. Unwritten shadow entries keep their previous values, which equal the active set after any commit.
- Repeat writes to the same index before commit: the last one wins.
- No arithmetic or saturation is applied. Values pass through bit-exact.

## Timing
- Reset (asynchronous, active-high):
  - state=IDLE.
  - Shadow and active sets take the `*_RST` parameter values.
  - `written_mask`=0, `update_pending`=0, `update_done`=0, `addr_err`=0.
  - `wr_ready`=1 once `Reset` deasserts.
- `wr_ready` is a registered function of state. It drops in the cycle after the accepting `wr_last` edge.
- Commit latency:
  - Active outputs change on the clock edge of the first `sample_tick` that arrives strictly after the cycle in which `wr_last` was accepted.
  - `sample_tick` in the same cycle as that acceptance does not commit.
  - `update_done` is high in the cycle following that edge, aligned with the new outputs.
- `sample_tick` in IDLE or COLLECT has no effect on the outputs.
- Active outputs are registered. They change only on a commit edge or on reset, never combinationally.
- Reset mid-COLLECT or mid-ARMED discards all staged data. The outputs return to the parameter values.

## Structure
- Shared package `synth_filter_pkg`:
  - coefficient index enum (`COEF_B0`..`COEF_A2`, 3 bits);
  - `coef_t` (signed [15:0]);
  - `coef_set_t` (array of 6 `coef_t`);
  - loader state enum;
  - default reset coefficient constants.
- The shadow bank is natural as sub-module `coef_bank`: 6×16 register file with indexed write, per-entry written flags, and a parallel-read output.
- The FSM and active registers stay in the top module.

## Test plan
- Reset release: all outputs equal the parameter defaults (b0=a0=16'sh7FFF, others 0), `wr_ready`=1, `written_mask`=0.
- Full set: write b0=0x1000, b1=0x2000, b2=0x1000, a0=0x7FFF, a1=0xC000, a2=0x2000, with `wr_last` on a2. `wr_ready` drops and outputs are unchanged until `sample_tick`. On that edge the outputs update, `update_done` pulses once, and the mask clears.
- Partial set plus invalid address:
  - Write a1=0x1234, then addr 7 with `wr_last`.
  - `addr_err` pulses and the mask reads 6'b010000.
  - After the tick only a1 changes; all other outputs hold.
- Tick coincident with the `wr_last` acceptance: no commit that cycle. Commit occurs on the next `sample_tick`, e.g. 48 cycles later.
- Backpressure: hold `wr_valid` during ARMED with data 0x5555 to b0. The write is not accepted until IDLE, and it lands in the next set, not the current one.
- Reset asserted asynchronously in ARMED, between clock edges: outputs snap to the defaults immediately, with no `update_done` pulse.

Source files
------------

// File: rtl/synth_filter_pkg.sv
// Shared types and constants for the biquad filter coefficient path.
// Coefficients are Q1.15. A set is six of them, indexed b0,b1,b2,a0,a1,a2.
package synth_filter_pkg;

  typedef enum logic [2:0] {
    COEF_B0 = 3'd0,
    COEF_B1 = 3'd1,
    COEF_B2 = 3'd2,
    COEF_A0 = 3'd3,
    COEF_A1 = 3'd4,
    COEF_A2 = 3'd5
  } coef_idx_e;

  localparam int unsigned NUM_COEF = 6;

  typedef logic signed [15:0] coef_t;
  typedef coef_t [NUM_COEF-1:0] coef_set_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ARMED   = 2'd2
  } loader_state_e;

  localparam coef_t COEF_UNITY = 16'sh7FFF;
  localparam coef_t COEF_ZERO  = 16'sh0000;

  function automatic logic coef_addr_valid(input logic [2:0] addr);
    return (addr <= 3'd5);
  endfunction

endpackage

// File: rtl/filter_coef_loader_coef_bank.sv
// Shadow coefficient bank: indexed write, per-entry written flags, parallel read.
module coef_bank
  import synth_filter_pkg::*;
#(
  parameter coef_set_t RST_SET = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we_i,
  input  logic [2:0]        waddr_i,
  input  coef_t             wdata_i,
  input  logic              clr_mask_i,
  output coef_set_t         rdata_o,
  output logic [NUM_COEF-1:0] mask_o
);

  coef_set_t             shadow_q;
  logic [NUM_COEF-1:0]   mask_q;

  // Writes never coincide with a mask clear: the loader refuses writes while armed.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow_q <= RST_SET;
      mask_q   <= '0;
    end else begin
      if (we_i) begin
        shadow_q[waddr_i] <= wdata_i;
        mask_q[waddr_i]   <= 1'b1;
      end
      if (clr_mask_i) begin
        mask_q <= '0;
      end
    end
  end

  assign rdata_o = shadow_q;
  assign mask_o  = mask_q;

endmodule

// File: rtl/filter_coef_loader.sv
// Stages coefficient writes in a shadow bank and commits the whole set to the
// filter on a sample strobe, so the filter never sees a mixed old/new set.
module filter_coef_loader
  import synth_filter_pkg::*;
#(
  parameter coef_t B0_RST = 16'sh7FFF,
  parameter coef_t B1_RST = 16'sh0000,
  parameter coef_t B2_RST = 16'sh0000,
  parameter coef_t A0_RST = 16'sh7FFF,
  parameter coef_t A1_RST = 16'sh0000,
  parameter coef_t A2_RST = 16'sh0000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               sample_tick,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_addr,
  input  logic signed [15:0] wr_data,
  input  logic               wr_last,
  output logic signed [15:0] b0,
  output logic signed [15:0] b1,
  output logic signed [15:0] b2,
  output logic signed [15:0] a0,
  output logic signed [15:0] a1,
  output logic signed [15:0] a2,
  output logic [5:0]         written_mask,
  output logic               update_pending,
  output logic               update_done,
  output logic               addr_err
);

  localparam coef_set_t RST_SET = {A2_RST, A1_RST, A0_RST, B2_RST, B1_RST, B0_RST};

  loader_state_e state_q, state_d;
  coef_set_t     active_q;
  coef_set_t     shadow_s;
  logic          wr_ready_q;
  logic          pending_q;
  logic          done_q;
  logic          addr_err_q;
  logic          accept_s;
  logic          addr_ok_s;
  logic          commit_s;

  assign accept_s  = wr_valid & wr_ready_q;
  assign addr_ok_s = coef_addr_valid(wr_addr);

  coef_bank #(
    .RST_SET (RST_SET)
  ) u_bank (
    .Clk        (Clk),
    .Reset      (Reset),
    .we_i       (accept_s & addr_ok_s),
    .waddr_i    (wr_addr),
    .wdata_i    (wr_data),
    .clr_mask_i (commit_s),
    .rdata_o    (shadow_s),
    .mask_o     (written_mask)
  );

  // Next-state logic; a commit only happens from ARMED, so a tick that
  // coincides with the wr_last acceptance is ignored.
  always_comb begin
    state_d  = state_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = wr_last ? ST_ARMED : ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (accept_s && wr_last) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_ARMED: begin
        if (sample_tick) begin
          commit_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, handshake flags and the active set the filter consumes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      wr_ready_q <= 1'b1;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      active_q   <= RST_SET;
    end else begin
      state_q    <= state_d;
      wr_ready_q <= (state_d != ST_ARMED);
      pending_q  <= (state_d == ST_ARMED);
      done_q     <= commit_s;
      addr_err_q <= accept_s & ~addr_ok_s;
      if (commit_s) begin
        active_q <= shadow_s;
      end
    end
  end

  assign wr_ready       = wr_ready_q;
  assign update_pending = pending_q;
  assign update_done    = done_q;
  assign addr_err       = addr_err_q;

  assign b0 = active_q[COEF_B0];
  assign b1 = active_q[COEF_B1];
  assign b2 = active_q[COEF_B2];
  assign a0 = active_q[COEF_A0];
  assign a1 = active_q[COEF_A1];
  assign a2 = active_q[COEF_A2];

endmodule

// File: tb/tb_filter_coef_loader.sv
// Directed bench for filter_coef_loader with hand-computed expectations.
module tb_filter_coef_loader;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               sample_tick;
  logic               wr_valid;
  logic               wr_ready;
  logic [2:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic               wr_last;
  logic signed [15:0] b0, b1, b2, a0, a1, a2;
  logic [5:0]         written_mask;
  logic               update_pending;
  logic               update_done;
  logic               addr_err;

  int total = 0;
  int bad   = 0;

  filter_coef_loader dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .sample_tick    (sample_tick),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .b0             (b0),
    .b1             (b1),
    .b2             (b2),
    .a0             (a0),
    .a1             (a1),
    .a2             (a2),
    .written_mask   (written_mask),
    .update_pending (update_pending),
    .update_done    (update_done),
    .addr_err       (addr_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_set(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input logic [15:0] e4, input logic [15:0] e5);
    check({tag, ".b0"}, b0, e0);
    check({tag, ".b1"}, b1, e1);
    check({tag, ".b2"}, b2, e2);
    check({tag, ".a0"}, a0, e3);
    check({tag, ".a1"}, a1, e4);
    check({tag, ".a2"}, a2, e5);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic write(input logic [2:0] addr, input logic [15:0] data, input logic last);
    int n = 0;
    while (!wr_ready && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("wr_ready_wait", {15'd0, wr_ready}, 16'd1);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    wr_last  = last;
    @(posedge Clk); #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    @(posedge Clk); #1;
    sample_tick = 1'b0;
  endtask

  initial begin
    Reset       = 1'b1;
    sample_tick = 1'b0;
    wr_valid    = 1'b0;
    wr_addr     = 3'd0;
    wr_data     = 16'h0000;
    wr_last     = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    // Reset state
    check_set("rst", 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000);
    check("rst.ready", {15'd0, wr_ready}, 16'd1);
    check("rst.mask", {10'd0, written_mask}, 16'h0000);
    check("rst.pend", {15'd0, update_pending}, 16'd0);
    check("rst.done", {15'd0, update_done}, 16'd0);
    check("rst.aerr", {15'd0, addr_err}, 16'd0);

    // Full set, commit on tick
    write(3'd0, 16'h1000, 1'b0);
    write(3'd1, 16'h2000, 1'b0);
    write(3'd2, 16'h1000, 1'b0);
    write(3'd3, 16'h7FFF, 1'b0);
    write(3'd4, 16'hC000, 1'b0);
    write(3'd5, 16'h2000, 1'b1);
    check("full.ready", {15'd0, wr_ready}, 16'd0);
    check("full.pend", {15'd0, update_pending}, 16'd1);
    check("full.mask", {10'd0, written_mask}, 16'h003F);
    repeat (3) @(posedge Clk);
    #1;
    check_set("full.hold", 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000);
    check("full.done0", {15'd0, update_done}, 16'd0);
    tick();
    check_set("full.new", 16'h1000, 16'h2000, 16'h1000, 16'h7FFF, 16'hC000, 16'h2000);
    check("full.done", {15'd0, update_done}, 16'd1);
    check("full.mask0", {10'd0, written_mask}, 16'h0000);
    check("full.ready1", {15'd0, wr_ready}, 16'd1);
    check("full.pend0", {15'd0, update_pending}, 16'd0);
    @(posedge Clk); #1;
    check("full.done1", {15'd0, update_done}, 16'd0);

    // Partial set plus invalid address
    write(3'd4, 16'h1234, 1'b0);
    check("part.mask", {10'd0, written_mask}, 16'h0010);
    check("part.aerr0", {15'd0, addr_err}, 16'd0);
    write(3'd7, 16'hBEEF, 1'b1);
    check("part.aerr", {15'd0, addr_err}, 16'd1);
    check("part.mask2", {10'd0, written_mask}, 16'h0010);
    check("part.ready", {15'd0, wr_ready}, 16'd0);
    @(posedge Clk); #1;
    check("part.aerr1", {15'd0, addr_err}, 16'd0);
    tick();
    check_set("part.new", 16'h1000, 16'h2000, 16'h1000, 16'h7FFF, 16'h1234, 16'h2000);
    check("part.done", {15'd0, update_done}, 16'd1);

    // Tick coincident with wr_last acceptance does not commit
    wr_valid    = 1'b1;
    wr_addr     = 3'd1;
    wr_data     = 16'h0ABC;
    wr_last     = 1'b1;
    sample_tick = 1'b1;
    @(posedge Clk); #1;
    wr_valid    = 1'b0;
    wr_last     = 1'b0;
    sample_tick = 1'b0;
    check("coin.b1", b1, 16'h2000);
    check("coin.pend", {15'd0, update_pending}, 16'd1);
    check("coin.done", {15'd0, update_done}, 16'd0);
    repeat (47) @(posedge Clk);
    #1;
    check("coin.b1hold", b1, 16'h2000);
    tick();
    check("coin.b1new", b1, 16'h0ABC);
    check("coin.done1", {15'd0, update_done}, 16'd1);

    // Backpressure: a write held during ARMED lands in the next set
    write(3'd2, 16'h0777, 1'b1);
    wr_valid = 1'b1;
    wr_addr  = 3'd0;
    wr_data  = 16'h5555;
    wr_last  = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("bp.ready", {15'd0, wr_ready}, 16'd0);
    check("bp.mask", {10'd0, written_mask}, 16'h0004);
    tick();
    check("bp.b2", b2, 16'h0777);
    check("bp.b0", b0, 16'h1000);
    check("bp.mask0", {10'd0, written_mask}, 16'h0000);
    @(posedge Clk); #1;
    wr_valid = 1'b0;
    check("bp.mask1", {10'd0, written_mask}, 16'h0001);
    check("bp.b0hold", b0, 16'h1000);
    write(3'd3, 16'h4000, 1'b1);
    tick();
    check("bp.b0new", b0, 16'h5555);
    check("bp.a0new", a0, 16'h4000);

    // Asynchronous reset while ARMED
    write(3'd0, 16'h0111, 1'b1);
    check("ar.pend", {15'd0, update_pending}, 16'd1);
    sample_tick = 1'b1;
    #3 Reset = 1'b1;
    #1;
    check_set("ar.snap", 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000);
    check("ar.done", {15'd0, update_done}, 16'd0);
    check("ar.pend0", {15'd0, update_pending}, 16'd0);
    @(posedge Clk); #1;
    sample_tick = 1'b0;
    Reset = 1'b0;
    check("ar.ready", {15'd0, wr_ready}, 16'd1);
    tick();
    check("ar.idletick.b0", b0, 16'h7FFF);
    check("ar.idletick.done", {15'd0, update_done}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
